shift_ram_ctrl: RTL

- Sequencer for the 16-bit shift RAM that holds the image and weight buffer: loads exactly DEPTH words from an upstream valid/ready source, then streams them back out to the compute datapath through a valid/ready interface.
- Drives the RAM enable, write-enable, address and write-data inputs, and consumes the RAM's auto-incrementing sequential read port.
- Absorbs the RAM's 1-cycle read latency and downstream backpressure with a 2-entry output skid FIFO.

---
 rtl/shift_ram_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/shift_ram_ctrl.sv
// Load/stream sequencer for the 16-bit shift RAM that holds the image and weight buffer.
// Writes DEPTH words from an upstream valid/ready source, then replays them through a
// 2-entry skid FIFO that absorbs the RAM read latency and downstream backpressure.
module shift_ram_ctrl #(
  parameter int unsigned DEPTH = 156800,
  parameter int unsigned AW    = 18,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          stream_start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          loaded,
  output logic          done,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);
  localparam logic [AW-1:0] LAST_W  = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOADED,
    S_STREAM,
    S_DRAIN,
    S_SPENT
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_issued;
  logic [AW-1:0] rd_acc;
  logic          inflight;
  logic          done_q;

  logic [DW-1:0] fifo_mem [2];
  logic          fifo_wp;
  logic          fifo_rp;
  logic [1:0]    fifo_cnt;

  logic          wr_fire;
  logic          rd_issue;
  logic          push;
  logic          pop;
  logic          last_pop;
  logic [2:0]    occ_after_pop;

  // Handshake and read-issue qualifiers; the issue check counts this cycle's pop so the
  // FIFO can be refilled while it drains, which keeps streaming at one word per cycle.
  always_comb begin
    wr_fire       = (state == S_LOAD) && in_valid;
    push          = inflight;
    pop           = (fifo_cnt != 2'd0) && out_ready;
    last_pop      = pop && (rd_acc == LAST_W);
    occ_after_pop = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
    rd_issue      = (state == S_STREAM) && (rd_issued != DEPTH_W) && (occ_after_pop < 3'd2);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start pulses outside their home state fall through unused
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (load_start) state_nxt = S_LOAD;
      S_LOAD:   if (wr_fire && (wr_cnt == LAST_W)) state_nxt = S_LOADED;
      S_LOADED: if (stream_start) state_nxt = S_STREAM;
      S_STREAM: if (rd_issued == DEPTH_W) state_nxt = S_DRAIN;
      S_DRAIN:  if (last_pop && (fifo_cnt == 2'd1) && !inflight) state_nxt = S_SPENT;
      S_SPENT:  state_nxt = S_SPENT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode; RAM strobes follow the accepted write or the issued read
  always_comb begin
    in_ready  = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    busy      = 1'b0;
    loaded    = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    done      = done_q;

    in_ready  = (state == S_LOAD);
    busy      = (state == S_LOAD) || (state == S_STREAM) || (state == S_DRAIN);
    loaded    = (state == S_LOADED);

    if (wr_fire) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = wr_cnt;
      ram_wdata = in_data;
    end else if (rd_issue) begin
      ram_en    = 1'b1;
    end

    out_valid = (fifo_cnt != 2'd0);
    if (out_valid) begin
      out_data = fifo_mem[fifo_rp];
      out_last = (rd_acc == LAST_W);
    end
  end

  // Pass counters, read-latency tracker and completion pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt    <= '0;
      rd_issued <= '0;
      rd_acc    <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (wr_fire) wr_cnt <= wr_cnt + AW'(1);
      if (rd_issue) rd_issued <= rd_issued + AW'(1);
      if (pop) rd_acc <= rd_acc + AW'(1);
      inflight <= rd_issue;
      done_q   <= (state == S_DRAIN) && (state_nxt == S_SPENT);
    end
  end

  // Two-entry skid FIFO fed by the registered RAM read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wp] <= ram_rdata;
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

endmodule
